// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester handshakes and the shared memory bus of the
//   two-port memory arbiter.
//   master : requester/system side; drives req/we/addr/wdata and mem_rdata.
//   slave  : arbiter side; drives ack/rdata/gnt and mem_addr/mem_wdata/mem_write.
interface mem_port_arbiter_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16
);
    logic                 req0, req1;
    logic                 we0, we1;
    logic [BITS_ADDR-1:0] addr0, addr1;
    logic [BITS_DATA-1:0] wdata0, wdata1;
    logic                 ack0, ack1;
    logic [BITS_DATA-1:0] rdata0, rdata1;
    logic                 gnt0, gnt1;
    logic [BITS_ADDR-1:0] mem_addr;
    logic [BITS_DATA-1:0] mem_wdata;
    logic                 mem_write;
    logic [BITS_DATA-1:0] mem_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, gnt0, gnt1, mem_addr, mem_wdata, mem_write
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, gnt0, gnt1, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between requester 0 (CPU) and requester 1
//   (loader/DMA). Each access runs IDLE -> ACCESS (MEM_LAT+1 cycles) -> DONE,
//   with a one-cycle ack in DONE. Conflicts are resolved round-robin.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_port_arbiter_if.slave (requester handshakes + memory bus)
// All outputs are registered.
module mem_port_arbiter #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16,
    parameter int MEM_LAT   = 1
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 prio;      // 1 = requester 1 wins the next conflict
    logic                 ack0, ack1, gnt0, gnt1, mem_write;
    logic [BITS_ADDR-1:0] mem_addr;
    logic [BITS_DATA-1:0] mem_wdata, rdata0, rdata1;
    logic                 win1;

    // Requester 1 wins when it is alone, or on a conflict when it holds priority.
    assign win1 = bus.req1 & (~bus.req0 | prio);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            prio      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        mem_addr  <= win1 ? bus.addr1  : bus.addr0;
                        mem_wdata <= win1 ? bus.wdata1 : bus.wdata0;
                        mem_write <= win1 ? bus.we1    : bus.we0;
                        gnt0      <= ~win1;
                        gnt1      <= win1;
                        // Next conflict goes to whoever did not get this grant.
                        prio      <= ~win1;
                        cnt       <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write strobe only lives in the first ACCESS cycle.
                    mem_write <= 1'b0;
                    if (cnt == LAST) begin
                        if (gnt1) begin
                            rdata1 <= bus.mem_rdata;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= bus.mem_rdata;
                            ack0   <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0      = ack0;
    assign bus.ack1      = ack1;
    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.rdata0    = rdata0;
    assign bus.rdata1    = rdata1;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_write = mem_write;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench: one arbiter built with MEM_LAT=1 (registered-read memory
//   model) and one with MEM_LAT=0 (combinational-read memory model).
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    int   both_gnt = 0, both_ack = 0, ack0_cnt = 0, ack1_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.BITS_DATA(32), .BITS_ADDR(16)) b1 ();
    mem_port_arbiter_if #(.BITS_DATA(32), .BITS_ADDR(16)) b0 ();

    mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));

    logic [31:0] mem1 [256];
    logic [31:0] mem0 [256];

    // One-cycle registered-read memory for the MEM_LAT=1 build.
    always @(posedge clk) begin
        if (b1.mem_write) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
        b1.mem_rdata <= mem1[b1.mem_addr[7:0]];
    end

    // Combinational-read memory for the MEM_LAT=0 build.
    always @(posedge clk)
        if (b0.mem_write) mem0[b0.mem_addr[7:0]] <= b0.mem_wdata;
    assign b0.mem_rdata = mem0[b0.mem_addr[7:0]];

    always @(negedge clk) begin
        if (b1.gnt0 & b1.gnt1) both_gnt++;
        if (b1.ack0 & b1.ack1) both_ack++;
        if (b1.ack0) ack0_cnt++;
        if (b1.ack1) ack1_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = '0;
            mem0[i] = '0;
        end
        mem1[8'h10] = 32'hDEADBEEF;
        mem1[8'h01] = 32'hA1A1A1A1;
        mem1[8'h02] = 32'hB2B2B2B2;
        mem0[8'h20] = 32'h0000CAFE;
        b1.mem_rdata = '0;
        {b1.req0, b1.req1, b1.we0, b1.we1} = '0;
        {b1.addr0, b1.addr1, b1.wdata0, b1.wdata1} = '0;
        {b0.req0, b0.req1, b0.we0, b0.we1} = '0;
        {b0.addr0, b0.addr1, b0.wdata0, b0.wdata1} = '0;

        // Reset state
        reset = 1'b1;
        tick(2);
        chk("rst_gnt0", b1.gnt0, 0);
        chk("rst_gnt1", b1.gnt1, 0);
        chk("rst_ack0", b1.ack0, 0);
        chk("rst_memw", b1.mem_write, 0);
        chk("rst_maddr", b1.mem_addr, 0);
        chk("rst_mwdata", b1.mem_wdata, 0);
        chk("rst_rdata0", b1.rdata0, 0);
        chk("rst_rdata1", b1.rdata1, 0);
        chk("rst_l0_rdata0", b0.rdata0, 0);
        reset = 1'b0;

        // Single read by requester 0
        b1.req0 = 1; b1.we0 = 0; b1.addr0 = 16'h0010;
        tick(1);
        chk("rd_maddr", b1.mem_addr, 32'h10);
        chk("rd_gnt0", b1.gnt0, 1);
        chk("rd_memw", b1.mem_write, 0);
        tick(1);
        chk("rd_ack0_early", b1.ack0, 0);
        tick(1);
        chk("rd_ack0", b1.ack0, 1);
        chk("rd_rdata0", b1.rdata0, 32'hDEADBEEF);
        chk("rd_gnt1", b1.gnt1, 0);
        b1.req0 = 0;
        tick(1);
        chk("rd_ack0_drop", b1.ack0, 0);
        chk("rd_gnt0_drop", b1.gnt0, 0);
        chk("rd_rdata0_hold", b1.rdata0, 32'hDEADBEEF);

        // Single write by requester 1
        b1.req1 = 1; b1.we1 = 1; b1.addr1 = 16'h0004; b1.wdata1 = 32'h12345678;
        tick(1);
        chk("wr_memw", b1.mem_write, 1);
        chk("wr_maddr", b1.mem_addr, 32'h4);
        chk("wr_mwdata", b1.mem_wdata, 32'h12345678);
        chk("wr_gnt1", b1.gnt1, 1);
        tick(1);
        chk("wr_memw_clr", b1.mem_write, 0);
        chk("wr_maddr_hold", b1.mem_addr, 32'h4);
        tick(1);
        chk("wr_ack1", b1.ack1, 1);
        b1.req1 = 0; b1.we1 = 0;
        tick(1);
        chk("wr_ack1_drop", b1.ack1, 0);

        // Read back the written word
        b1.req0 = 1; b1.addr0 = 16'h0004;
        tick(3);
        chk("rb_ack0", b1.ack0, 1);
        chk("rb_rdata0", b1.rdata0, 32'h12345678);
        b1.req0 = 0;
        tick(1);

        // Simultaneous requests after reset alternate 0,1,0
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        b1.req0 = 1; b1.addr0 = 16'h0001;
        b1.req1 = 1; b1.addr1 = 16'h0002;
        for (int t = 0; t < 3; t++) begin
            tick(1);
            chk("arb_gnt0", b1.gnt0, (t % 2 == 0) ? 1 : 0);
            chk("arb_gnt1", b1.gnt1, (t % 2 == 1) ? 1 : 0);
            tick(2);
            if (t % 2 == 0) begin
                chk("arb_ack0", b1.ack0, 1);
                chk("arb_rdata0", b1.rdata0, 32'hA1A1A1A1);
            end else begin
                chk("arb_ack1", b1.ack1, 1);
                chk("arb_rdata1", b1.rdata1, 32'hB2B2B2B2);
            end
            tick(1);
            chk("arb_idle_gnt", {b1.gnt0, b1.gnt1}, 0);
        end
        b1.req0 = 0; b1.req1 = 0;
        tick(1);

        // Back-to-back reads from requester 0: new grant every 4 cycles
        b1.req0 = 1; b1.addr0 = 16'h0010;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            chk("b2b_gnt0", b1.gnt0, (i % 4 != 0) ? 1 : 0);
            chk("b2b_ack0", b1.ack0, (i % 4 == 3) ? 1 : 0);
            if (i == 11) b1.req0 = 0;
        end

        // Reset during first ACCESS cycle of a write aborts it
        b1.req0 = 1; b1.we0 = 1; b1.addr0 = 16'h0030; b1.wdata0 = 32'h55;
        tick(1);
        chk("ab_memw", b1.mem_write, 1);
        reset = 1'b1;
        b1.req0 = 0; b1.we0 = 0;
        tick(1);
        chk("ab_memw_clr", b1.mem_write, 0);
        chk("ab_ack0", b1.ack0, 0);
        chk("ab_gnt0", b1.gnt0, 0);
        reset = 1'b0;
        tick(6);
        chk("ab_ack0_total", ack0_cnt, 7);
        chk("ab_ack1_total", ack1_cnt, 2);
        chk("both_gnt", both_gnt, 0);
        chk("both_ack", both_ack, 0);

        // MEM_LAT = 0 build: ack two cycles after req sampled
        b0.req0 = 1; b0.we0 = 0; b0.addr0 = 16'h0020;
        tick(1);
        chk("l0_gnt0", b0.gnt0, 1);
        chk("l0_ack0_early", b0.ack0, 0);
        tick(1);
        chk("l0_ack0", b0.ack0, 1);
        chk("l0_rdata0", b0.rdata0, 32'h0000CAFE);
        b0.req0 = 0;
        tick(1);
        chk("l0_ack0_drop", b0.ack0, 0);
        chk("l0_gnt0_drop", b0.gnt0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
